// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the transmit FSM encoding used by the GMII frame
// path and the CRC-32 datapath.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Ethernet shifts LSB first, so the register runs on the bit-reversed polynomial.
  localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

  typedef logic [2:0] tx_state_t;
  localparam tx_state_t ST_IDLE     = 3'd0;
  localparam tx_state_t ST_PREAMBLE = 3'd1;
  localparam tx_state_t ST_SFD      = 3'd2;
  localparam tx_state_t ST_DATA     = 3'd3;
  localparam tx_state_t ST_PAD      = 3'd4;
  localparam tx_state_t ST_FCS      = 3'd5;
  localparam tx_state_t ST_IFG      = 3'd6;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 advance by one byte; the caller owns the register.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_c;

  always_comb begin
    w_c = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY_REFL) : (w_c >> 1);
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/gmii_frame_tx.sv
// GMII frame transmitter: preamble/SFD, streamed data, zero pad, CRC-32 FCS, IFG.
// The FSM state names the byte being loaded into the output register this cycle.
module gmii_frame_tx
  import eth_pkg::*;
#(
  parameter int MIN_LEN    = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 1);

  tx_state_t   r_state, w_state_nxt;
  logic [10:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [2:0]  r_phase, w_phase_nxt;
  logic [15:0] r_ifg, w_ifg_nxt;
  logic        r_abort, w_abort_nxt;
  logic [31:0] r_crc, w_crc_nxt, w_crc_upd, w_fcs;
  logic [7:0]  w_crc_byte, w_txd_nxt;
  logic        w_en_nxt, w_done_nxt, w_under_nxt;

  crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (w_crc_byte),
    .o_crc  (w_crc_upd)
  );

  assign s_ready    = (r_state == ST_DATA);
  assign w_crc_byte = (r_state == ST_DATA) ? s_data : 8'h00;
  assign w_cnt_inc  = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
  // An aborted frame sends the raw register, i.e. the bit-inverse of the true FCS.
  assign w_fcs      = r_abort ? r_crc : ~r_crc;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_ifg_nxt   = r_ifg;
    w_abort_nxt = r_abort;
    w_crc_nxt   = r_crc;
    w_en_nxt    = 1'b0;
    w_txd_nxt   = 8'h00;
    w_done_nxt  = 1'b0;
    w_under_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_valid) begin
          w_state_nxt = ST_PREAMBLE;
          w_en_nxt    = 1'b1;
          w_txd_nxt   = PREAMBLE_BYTE;
          w_crc_nxt   = CRC_INIT;
          w_cnt_nxt   = 11'd0;
          w_phase_nxt = 3'd0;
          w_abort_nxt = 1'b0;
        end
      end
      ST_PREAMBLE: begin
        w_en_nxt  = 1'b1;
        w_txd_nxt = PREAMBLE_BYTE;
        if (r_phase == 3'd5) w_state_nxt = ST_SFD;
        else                 w_phase_nxt = r_phase + 3'd1;
      end
      ST_SFD: begin
        w_en_nxt    = 1'b1;
        w_txd_nxt   = SFD_BYTE;
        w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_en_nxt = 1'b1;
        if (s_valid) begin
          w_txd_nxt = s_data;
          w_crc_nxt = w_crc_upd;
          w_cnt_nxt = w_cnt_inc;
          if (s_last) begin
            w_phase_nxt = 3'd0;
            w_state_nxt = ({1'b0, w_cnt_inc} < MIN_LEN_W) ? ST_PAD : ST_FCS;
          end
        end else begin
          // Underrun: first inverted FCS byte goes out now so the wire has no gap.
          w_txd_nxt   = r_crc[7:0];
          w_abort_nxt = 1'b1;
          w_phase_nxt = 3'd1;
          w_state_nxt = ST_FCS;
        end
      end
      ST_PAD: begin
        w_en_nxt  = 1'b1;
        w_crc_nxt = w_crc_upd;
        w_cnt_nxt = w_cnt_inc;
        if ({1'b0, w_cnt_inc} >= MIN_LEN_W) begin
          w_phase_nxt = 3'd0;
          w_state_nxt = ST_FCS;
        end
      end
      ST_FCS: begin
        w_en_nxt = 1'b1;
        case (r_phase[1:0])
          2'd0:    w_txd_nxt = w_fcs[7:0];
          2'd1:    w_txd_nxt = w_fcs[15:8];
          2'd2:    w_txd_nxt = w_fcs[23:16];
          default: w_txd_nxt = w_fcs[31:24];
        endcase
        if (r_phase[1:0] == 2'd3) begin
          w_ifg_nxt   = 16'd0;
          w_state_nxt = ST_IFG;
        end else begin
          w_phase_nxt = r_phase + 3'd1;
        end
      end
      ST_IFG: begin
        if (r_ifg == 16'd0) begin
          w_done_nxt  = ~r_abort;
          w_under_nxt = r_abort;
        end
        if (r_ifg == IFG_LAST) w_state_nxt = ST_IDLE;
        else                   w_ifg_nxt   = r_ifg + 16'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 11'd0;
      r_phase     <= 3'd0;
      r_ifg       <= 16'd0;
      r_abort     <= 1'b0;
      r_crc       <= CRC_INIT;
      gmii_tx_en  <= 1'b0;
      gmii_txd    <= 8'h00;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_ifg       <= w_ifg_nxt;
      r_abort     <= w_abort_nxt;
      r_crc       <= w_crc_nxt;
      gmii_tx_en  <= w_en_nxt;
      gmii_txd    <= w_txd_nxt;
      tx_busy     <= (w_state_nxt != ST_IDLE);
      tx_done     <= w_done_nxt;
      tx_underrun <= w_under_nxt;
    end
  end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Bench for gmii_frame_tx: two instances (MIN_LEN=0 and MIN_LEN=60) share one source;
// a reference frame model fills per-instance scoreboards checked as frames leave the wire.
module tb_gmii_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;

  logic       rdy0, en0, busy0, done0, und0;
  logic       rdy1, en1, busy1, done1, und1;
  logic [7:0] txd0, txd1;

  always #4 clk = ~clk;

  gmii_frame_tx #(.MIN_LEN(0), .IFG_CYCLES(12)) dut0 (
    .gmii_tx_clk(clk), .reset(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(rdy0), .gmii_tx_en(en0), .gmii_txd(txd0), .tx_busy(busy0),
    .tx_done(done0), .tx_underrun(und0)
  );

  gmii_frame_tx #(.MIN_LEN(60), .IFG_CYCLES(12)) dut1 (
    .gmii_tx_clk(clk), .reset(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(rdy1), .gmii_tx_en(en1), .gmii_txd(txd1), .tx_busy(busy1),
    .tx_done(done1), .tx_underrun(und1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit ignore  = 1'b0;

  logic [7:0] frm[$];
  logic [7:0] eb[2][$];
  int         el[2][$];
  logic [7:0] cap[2][$];
  logic [7:0] last_frame[2][$];
  int         last_len[2];
  int         done_cnt[2];
  int         und_cnt[2];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  task automatic build_frame(input int len, input logic [7:0] base);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(base + 8'(i));
  endtask

  // Expected wire image of the current frm for instance d.
  task automatic push_exp(input int d, input int drop);
    int minlen, n, cnt;
    logic [31:0] c, f;
    minlen = (d == 1) ? 60 : 0;
    c = 32'hFFFF_FFFF;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin eb[d].push_back(8'h55); cnt++; end
    eb[d].push_back(8'hD5); cnt++;
    n = (drop >= 0) ? drop : frm.size();
    for (int i = 0; i < n; i++) begin
      eb[d].push_back(frm[i]); c = crc_step(c, frm[i]); cnt++;
    end
    if (drop < 0) begin
      for (int i = n; i < minlen; i++) begin
        eb[d].push_back(8'h00); c = crc_step(c, 8'h00); cnt++;
      end
    end
    f = (drop >= 0) ? c : ~c;
    for (int k = 0; k < 4; k++) begin eb[d].push_back(f[8*k +: 8]); cnt++; end
    el[d].push_back(cnt);
  endtask

  task automatic frame_end(input int d);
    int n_exp, nbad, first;
    logic [7:0] e;
    last_len[d]   = cap[d].size();
    last_frame[d] = cap[d];
    if (!ignore) begin
      if (el[d].size() == 0) begin
        chk($sformatf("d%0d unexpected frame", d), 64'(cap[d].size()), 64'd0);
      end else begin
        n_exp = el[d].pop_front();
        chk($sformatf("d%0d frame length", d), 64'(cap[d].size()), 64'(n_exp));
        nbad = 0; first = -1;
        for (int i = 0; i < n_exp; i++) begin
          e = eb[d].pop_front();
          if (i >= cap[d].size() || cap[d][i] !== e) begin
            nbad++;
            if (first < 0) first = i;
          end
        end
        chk($sformatf("d%0d frame byte diffs (first @%0d)", d, first), 64'(nbad), 64'd0);
      end
    end
    cap[d].delete();
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        cap[d].delete();
      end else begin
        if ((d == 1) ? en1 : en0) cap[d].push_back((d == 1) ? txd1 : txd0);
        else if (cap[d].size() != 0) frame_end(d);
        if ((d == 1) ? done1 : done0) done_cnt[d]++;
        if ((d == 1) ? und1 : und0)   und_cnt[d]++;
      end
    end
  end

  task automatic send_frame(input int drop, input bit hold);
    int i, guard;
    i = 0; guard = 0;
    s_valid = 1'b1; s_data = frm[0]; s_last = (frm.size() == 1);
    while (i < frm.size()) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        chk("send timeout", 64'd1, 64'd0);
        break;
      end
      if (rdy0 && rdy1) begin
        @(posedge clk); #1;
        i++;
        if (drop >= 0 && i == drop) begin
          s_valid = 1'b0; s_last = 1'b0;
          break;
        end
        if (i < frm.size()) begin
          s_data = frm[i]; s_last = (i == frm.size() - 1);
        end else if (!hold) begin
          s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin @(negedge clk); g++; end while ((busy0 || busy1 || en0 || en1) && g < 3000);
    if (g >= 3000) chk("idle timeout", 64'd1, 64'd0);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int         len;
    logic [7:0] base;
    int         drop;
    int         en0;
    int         en1;
    int         done;
    int         und;
  } vec_t;

  vec_t vt[6];

  initial begin
    int dn0, dn1, un0, un1, nz, gap, rbad, g;
    logic [31:0] fcs_got;

    vt[0] = '{len: 9,  base: 8'h31, drop: -1, en0: 21, en1: 72, done: 1, und: 0};
    vt[1] = '{len: 14, base: 8'hA0, drop: -1, en0: 26, en1: 72, done: 1, und: 0};
    vt[2] = '{len: 60, base: 8'h00, drop: -1, en0: 72, en1: 72, done: 1, und: 0};
    vt[3] = '{len: 64, base: 8'h40, drop: 20, en0: 32, en1: 32, done: 0, und: 1};
    vt[4] = '{len: 61, base: 8'h10, drop: -1, en0: 73, en1: 73, done: 1, und: 0};
    vt[5] = '{len: 1,  base: 8'hFF, drop: -1, en0: 13, en1: 72, done: 1, und: 0};

    repeat (3) @(negedge clk);
    chk("reset outputs", {rdy0, en0, txd0, busy0, done0, und0, rdy1, en1, txd1, busy1, done1, und1},
        64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      build_frame(vt[r].len, vt[r].base);
      push_exp(0, vt[r].drop);
      push_exp(1, vt[r].drop);
      dn0 = done_cnt[0]; dn1 = done_cnt[1]; un0 = und_cnt[0]; un1 = und_cnt[1];
      send_frame(vt[r].drop, 1'b0);
      wait_idle();
      chk($sformatf("v%0d d0 tx_en cycles", r), 64'(last_len[0]), 64'(vt[r].en0));
      chk($sformatf("v%0d d1 tx_en cycles", r), 64'(last_len[1]), 64'(vt[r].en1));
      chk($sformatf("v%0d d0 tx_done", r), 64'(done_cnt[0] - dn0), 64'(vt[r].done));
      chk($sformatf("v%0d d1 tx_done", r), 64'(done_cnt[1] - dn1), 64'(vt[r].done));
      chk($sformatf("v%0d d0 tx_underrun", r), 64'(und_cnt[0] - un0), 64'(vt[r].und));
      chk($sformatf("v%0d d1 tx_underrun", r), 64'(und_cnt[1] - un1), 64'(vt[r].und));
      if (r == 0) begin
        fcs_got = {last_frame[0][17], last_frame[0][18], last_frame[0][19], last_frame[0][20]};
        chk("123456789 FCS bytes", 64'(fcs_got), 64'h2639F4CB);
      end
      if (r == 1) begin
        nz = 0;
        for (int i = 22; i < 68; i++) if (last_frame[1][i] !== 8'h00) nz++;
        chk("pad bytes nonzero", 64'(nz), 64'd0);
      end
    end

    // Back-to-back frames with s_valid held through the gap.
    build_frame(60, 8'h20);
    push_exp(0, -1); push_exp(1, -1);
    send_frame(-1, 1'b1);
    build_frame(60, 8'h90);
    push_exp(0, -1); push_exp(1, -1);
    gap = 0; rbad = 0;
    fork
      send_frame(-1, 1'b0);
      begin
        g = 0;
        while (en1 && g < 200) begin @(negedge clk); g++; end
        while (!en1 && gap < 100) begin
          if (rdy1) rbad++;
          gap++;
          @(negedge clk);
        end
        chk("b2b gap cycles", 64'(gap), 64'd12);
        chk("b2b s_ready in gap", 64'(rbad), 64'd0);
        chk("b2b first byte after gap", 64'(txd1), 64'h55);
      end
    join
    wait_idle();

    // Reset in the middle of padding.
    ignore = 1'b1;
    build_frame(14, 8'h61);
    send_frame(-1, 1'b0);
    repeat (20) @(negedge clk);
    chk("in PAD before reset", {en1, txd1}, {1'b1, 8'h00});
    #2 rst = 1'b1;
    #1 chk("async reset drops tx", {en0, txd0, en1, txd1, busy1}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    ignore = 1'b0;

    build_frame(20, 8'h5A);
    push_exp(0, -1); push_exp(1, -1);
    dn1 = done_cnt[1];
    send_frame(-1, 1'b0);
    wait_idle();
    chk("post-reset d1 tx_en cycles", 64'(last_len[1]), 64'd72);
    chk("post-reset d0 tx_en cycles", 64'(last_len[0]), 64'd32);
    chk("post-reset d1 tx_done", 64'(done_cnt[1] - dn1), 64'd1);
    chk("pending expected frames", 64'(el[0].size() + el[1].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
